sipo_deser: RTL and testbench

Serial-in/parallel-out deserializer that sits directly upstream of the parallel-in/parallel-out register stage. It gathers a valid-qualified serial bit stream into W-bit words and presents each word on a parallel output with a valid/ready handshake. The `po` bus is the `pi` input of the next stage. A one-word output register plus a held-word state absorb downstream stalls, and `si_ready` backpressures the serial source.

---
 rtl/pipo_pkg.sv | 9 +
 rtl/sipo_deser_if.sv | 10 +
 rtl/sipo_shift_core.sv | 40 ++++
 rtl/sipo_deser.sv | 46 ++++
 tb/tb_sipo_deser.sv | 91 +++++++++
 5 files changed

// File: rtl/pipo_pkg.sv
// pipo_pkg: shared word-width, bit-order constants and counter sizing for the serial/parallel stages
package pipo_pkg;
  localparam int DEFAULT_W = 4;
  localparam bit MSB_FIRST = 1'b1;
  localparam bit LSB_FIRST = 1'b0;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial input and parallel output handshake bundle of the deserializer
// slave side (deserializer): si/si_valid in, si_ready out; po/po_valid out, po_ready in.
// master side (source/sink): the mirror image.
interface sipo_deser_if #(parameter int W = pipo_pkg::DEFAULT_W) ();
  logic si, si_valid, si_ready;
  logic [W-1:0] po;
  logic po_valid, po_ready;
  modport master (output si, si_valid, po_ready, input si_ready, po, po_valid);
  modport slave (input si, si_valid, po_ready, output si_ready, po, po_valid);
endinterface

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: shifter, bit counter and bit-order mux of the deserializer
// clk/rst(async, active low)/clr; shift_i accepts si_i; take_i means the finished word leaves;
// done_o pulses on the accepted last bit; full_o flags a held word; word_o is the word being offered.
module sipo_shift_core #(
  parameter int W = pipo_pkg::DEFAULT_W,
  parameter bit MSB_FIRST = pipo_pkg::MSB_FIRST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_i,
  input  logic         si_i,
  input  logic         take_i,
  output logic         done_o,
  output logic         full_o,
  output logic [W-1:0] word_o
);
  import pipo_pkg::*;
  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [CW-1:0] HELD = CW'(W);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] sh_q, sh_d;
  assign full_o = cnt_q == HELD;
  assign done_o = shift_i && cnt_q == LAST;
  // offers the completing word on the W-th bit, otherwise the held shifter contents
  assign word_o = sh_d;
  always_comb begin
    sh_d = clr ? '0 : shift_i ? (MSB_FIRST ? {sh_q[W-2:0], si_i} : {si_i, sh_q[W-1:1]}) : sh_q;
    cnt_d = clr || take_i ? '0 : done_o ? HELD : shift_i ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      sh_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
    end
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with a registered, stall-absorbing word output
// clk; rst async active low; clr sync clear of partial/held/pending words;
// bus (slave): si/si_valid/si_ready serial side, po/po_valid/po_ready parallel side.
module sipo_deser #(
  parameter int W = pipo_pkg::DEFAULT_W,
  parameter bit MSB_FIRST = pipo_pkg::MSB_FIRST
) (
  input logic       clk,
  input logic       rst,
  input logic       clr,
  sipo_deser_if.slave bus
);
  import pipo_pkg::*;
  logic shift, done, full, take;
  logic [W-1:0] word, po_q, po_d;
  logic po_valid_q, po_valid_d;
  assign bus.si_ready = !full;
  assign shift = bus.si_valid && !full && !clr;
  // output register is free when empty or being consumed on this same edge
  assign take = !clr && (done || full) && (!po_valid_q || bus.po_ready);
  assign bus.po = po_q;
  assign bus.po_valid = po_valid_q;
  always_comb begin
    po_d = take ? word : po_q;
    po_valid_d = clr ? 1'b0 : take ? 1'b1 : po_valid_q && !bus.po_ready;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      po_q <= '0;
      po_valid_q <= 1'b0;
    end else begin
      po_q <= po_d;
      po_valid_q <= po_valid_d;
    end
  sipo_shift_core #(.W(W), .MSB_FIRST(MSB_FIRST)) u_core (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .shift_i(shift),
    .si_i(bus.si),
    .take_i(take),
    .done_o(done),
    .full_o(full),
    .word_o(word)
  );
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: table-driven check of MSB-first and LSB-first deserializers fed the same stream
module tb_sipo_deser;
  typedef struct {
    logic v, s, r, c, ev, er, cp, rs;
    logic [3:0] ep;
  } vec_t;
  logic clk, rst, clr, si, si_valid, po_ready;
  int n = 0, bad = 0;
  vec_t tab[$];
  sipo_deser_if #(.W(4)) bm ();
  sipo_deser_if #(.W(4)) bl ();
  assign bm.si = si;
  assign bm.si_valid = si_valid;
  assign bm.po_ready = po_ready;
  assign bl.si = si;
  assign bl.si_valid = si_valid;
  assign bl.po_ready = po_ready;
  sipo_deser #(.W(4), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .clr(clr), .bus(bm));
  sipo_deser #(.W(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .clr(clr), .bus(bl));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [3:0] rev(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction
  function automatic void a(input logic v, s, r, c, ev, er, cp, input logic [3:0] ep, input logic rs = 1'b0);
    vec_t t;
    t.v = v; t.s = s; t.r = r; t.c = c; t.ev = ev; t.er = er; t.cp = cp; t.ep = ep; t.rs = rs;
    tab.push_back(t);
  endfunction
  task automatic check(input string nm, input logic ev, er, cp, input logic [3:0] ep);
    n++;
    if (bm.po_valid !== ev || bm.si_ready !== er || bl.po_valid !== ev || bl.si_ready !== er ||
        (cp && (bm.po !== ep || bl.po !== rev(ep)))) begin
      bad++;
      $display("FAIL %s: msb valid/ready/po=%b/%b/%b lsb=%b/%b/%b, want valid=%b ready=%b po=%b/%b (po checked=%b)",
               nm, bm.po_valid, bm.si_ready, bm.po, bl.po_valid, bl.si_ready, bl.po, ev, er, ep, rev(ep), cp);
    end
  endtask
  initial begin
    logic [3:0] wds [4];
    logic [3:0] w;
    wds[0] = 4'b0101; wds[1] = 4'b1000; wds[2] = 4'b0011; wds[3] = 4'b0111;
    // word 0101, consumed immediately
    a(1,0,1,0, 0,1,0,4'h0); a(1,1,1,0, 0,1,0,4'h0); a(1,0,1,0, 0,1,0,4'h0);
    a(1,1,1,0, 1,1,1,4'b0101); a(0,0,1,0, 0,1,0,4'h0);
    // stall: 1000 held on po, 0011 held in the shifter, source backpressured
    a(1,1,0,0, 0,1,0,4'h0); a(1,0,0,0, 0,1,0,4'h0); a(1,0,0,0, 0,1,0,4'h0);
    a(1,0,0,0, 1,1,1,4'b1000); a(1,0,0,0, 1,1,1,4'b1000); a(1,0,0,0, 1,1,1,4'b1000);
    a(1,1,0,0, 1,1,1,4'b1000); a(1,1,0,0, 1,0,1,4'b1000); a(1,1,0,0, 1,0,1,4'b1000);
    a(0,0,1,0, 1,1,1,4'b0011); a(0,0,0,0, 1,1,1,4'b0011); a(0,0,1,0, 0,1,0,4'h0);
    // continuous stream, each word consumed on the edge bringing the next word's last bit
    for (int k = 0; k < 4; k++)
      for (int b = 3; b >= 0; b--) begin
        w = wds[k];
        if (b == 0) a(1, w[b], 1, 0, 1, 1, 1, w);
        else if (k == 0) a(1, w[b], 0, 0, 0, 1, 0, 4'h0);
        else a(1, w[b], 0, 0, 1, 1, 1, wds[k-1]);
      end
    a(0,0,1,0, 0,1,0,4'h0);
    // word 1111 pending plus partial 11, then async reset, then 0111
    a(1,1,0,0, 0,1,0,4'h0); a(1,1,0,0, 0,1,0,4'h0); a(1,1,0,0, 0,1,0,4'h0);
    a(1,1,0,0, 1,1,1,4'b1111); a(1,1,0,0, 1,1,1,4'b1111); a(1,1,0,0, 1,1,1,4'b1111);
    a(0,0,0,0, 0,1,1,4'h0, 1'b1);
    a(1,0,1,0, 0,1,0,4'h0); a(1,1,1,0, 0,1,0,4'h0); a(1,1,1,0, 0,1,0,4'h0);
    a(1,1,1,0, 1,1,1,4'b0111);
    // three bits, clr with a bit presented and a word pending, then 0011
    a(1,1,0,0, 1,1,1,4'b0111); a(1,0,0,0, 1,1,1,4'b0111); a(1,1,0,0, 1,1,1,4'b0111);
    a(1,1,0,1, 0,1,1,4'b0111);
    a(1,0,1,0, 0,1,0,4'h0); a(1,0,1,0, 0,1,0,4'h0); a(1,1,1,0, 0,1,0,4'h0);
    a(1,1,1,0, 1,1,1,4'b0011); a(0,0,1,0, 0,1,0,4'h0);
    rst = 1'b0; clr = 1'b0; si = 1'b0; si_valid = 1'b0; po_ready = 1'b0;
    #2 check("reset", 1'b0, 1'b1, 1'b1, 4'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    foreach (tab[i]) begin
      if (tab[i].rs) begin
        si_valid = 1'b0; po_ready = 1'b0; clr = 1'b0;
        #3 rst = 1'b0;
        #1 check("async_reset", tab[i].ev, tab[i].er, tab[i].cp, tab[i].ep);
        #3 rst = 1'b1;
        @(posedge clk); #1;
      end else begin
        si = tab[i].s; si_valid = tab[i].v; po_ready = tab[i].r; clr = tab[i].c;
        @(posedge clk); #1;
        check($sformatf("vec%0d", i), tab[i].ev, tab[i].er, tab[i].cp, tab[i].ep);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
